// File: rtl/mem_stage_if.sv
// mem_stage_if: single-outstanding data-memory port (request + response).
interface mem_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic [29:0] req_addr;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_we, req_be, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_be, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and writeback.
// Issues at most one outstanding data-memory access per uop, aligns and
// extends load data, and turns alignment/bus faults into exception codes.

package Uop;
  typedef enum logic [1:0] {
    EX_NONE      = 2'd0,
    EX_DECODE    = 2'd1,
    EX_MEM_ALIGN = 2'd2,
    EX_MEM_MISS  = 2'd3
  } ex_t;

  localparam logic [1:0] MEM_OP_SZ_B = 2'b00;
  localparam logic [1:0] MEM_OP_SZ_H = 2'b01;
  localparam logic [1:0] MEM_OP_SZ_W = 2'b10;

  typedef struct packed {
    logic       en;
    logic       isSt;
    logic       signExtend;
    logic [1:0] sz;
  } mem_op_t;

  // 2 + 5 + 32 + 32 + 5 = 76 bits
  typedef struct packed {
    ex_t         ex;
    logic [4:0]  rd;
    logic [31:0] rdVal;
    logic [31:0] rs2Val;
    mem_op_t     memOp;
  } execute_t;

  // 2 + 5 + 32 = 39 bits
  typedef struct packed {
    ex_t         ex;
    logic [4:0]  rd;
    logic [31:0] rdVal;
  } memory_t;
endpackage

module mem_stage
  import Uop::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     in_valid,
  output logic     in_ready,
  input  execute_t in_uop,
  output logic     out_valid,
  input  logic     out_ready,
  output memory_t  out_uop,
  mem_stage_if.master dmem
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_p0;
  logic [4:0]  rd_p0;
  logic        is_st_p0;
  logic        sext_p0;
  logic [1:0]  sz_p0;

  logic        accept;
  logic        misaligned;
  logic        needs_access;
  memory_t     pass_result;
  memory_t     mem_result;

  // Size encoding 2'b11 behaves as a word everywhere below.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      MEM_OP_SZ_B: return 1'b0;
      MEM_OP_SZ_H: return a[0];
      default:     return a != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      MEM_OP_SZ_B: return 4'b0001 << a;
      MEM_OP_SZ_H: return 4'b0011 << a;
      default:     return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      MEM_OP_SZ_B: return {4{d[7:0]}};
      MEM_OP_SZ_H: return {2{d[15:0]}};
      default:     return d;
    endcase
  endfunction

  function automatic logic [31:0] align_load(input logic [31:0] rdata, input logic [1:0] a,
                                             input logic [1:0] sz, input logic sext);
    logic        [31:0] sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = rdata >> {a, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (sz)
      MEM_OP_SZ_B: return sext ? 32'(b) : {24'b0, sh[7:0]};
      MEM_OP_SZ_H: return sext ? 32'(h) : {16'b0, sh[15:0]};
      default:     return sh;
    endcase
  endfunction

  assign accept       = in_valid && in_ready;
  assign misaligned   = is_misaligned(in_uop.memOp.sz, in_uop.rdVal[1:0]);
  assign needs_access = (in_uop.ex == EX_NONE) && in_uop.memOp.en && !misaligned;

  assign pass_result.ex    = (in_uop.ex == EX_NONE && in_uop.memOp.en && misaligned)
                             ? EX_MEM_ALIGN : in_uop.ex;
  assign pass_result.rd    = in_uop.rd;
  assign pass_result.rdVal = in_uop.rdVal;

  // Result of the outstanding access once its response is on the bus.
  always_comb begin
    mem_result       = '0;
    mem_result.ex    = EX_NONE;
    mem_result.rd    = 5'd0;
    mem_result.rdVal = addr_p0;
    if (dmem.resp_err) begin
      mem_result.ex = EX_MEM_MISS;
    end else if (!is_st_p0) begin
      mem_result.rd    = rd_p0;
      mem_result.rdVal = align_load(dmem.resp_rdata, addr_p0[1:0], sz_p0, sext_p0);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && needs_access) state_d = REQ;
      REQ:     if (dmem.req_ready)         state_d = WAIT;
      WAIT:    if (dmem.resp_valid)        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: acceptance and request strobe.
  always_comb begin
    in_ready       = (state_q == IDLE) && (!out_valid || out_ready);
    dmem.req_valid = (state_q == REQ);
  end

  // --- stage p0: capture the access at accept; fields stay stable through REQ/WAIT ---
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_p0        <= '0;
      rd_p0          <= '0;
      is_st_p0       <= 1'b0;
      sext_p0        <= 1'b0;
      sz_p0          <= '0;
      dmem.req_addr  <= '0;
      dmem.req_we    <= 1'b0;
      dmem.req_be    <= '0;
      dmem.req_wdata <= '0;
    end else if (accept && needs_access) begin
      addr_p0        <= in_uop.rdVal;
      rd_p0          <= in_uop.rd;
      is_st_p0       <= in_uop.memOp.isSt;
      sext_p0        <= in_uop.memOp.signExtend;
      sz_p0          <= in_uop.memOp.sz;
      dmem.req_addr  <= in_uop.rdVal[31:2];
      dmem.req_we    <= in_uop.memOp.isSt;
      dmem.req_be    <= lane_be(in_uop.memOp.sz, in_uop.rdVal[1:0]);
      dmem.req_wdata <= lane_wdata(in_uop.memOp.sz, in_uop.rs2Val);
    end
  end

  // --- stage p1: output register, loaded by pass-through or by memory response ---
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_uop   <= '0;
    end else if (accept && !needs_access) begin
      out_valid <= 1'b1;
      out_uop   <= pass_result;
    end else if (state_q == WAIT && dmem.resp_valid) begin
      out_valid <= 1'b1;
      out_uop   <= mem_result;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
